// File: rtl/uart_rom_loader_pkg.sv
// Shared types and defaults for the UART program-ROM loader.
package uart_rom_loader_pkg;

  // Loader sequencing: hunt for sync byte, take word count, take data, hold image.
  typedef enum logic [1:0] {
    LD_HUNT  = 2'd0,
    LD_COUNT = 2'd1,
    LD_DATA  = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  // Serial receiver phases for one 8N1 character.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/single_port_ram.sv
// Single-port word RAM with one-cycle registered read; contents are not reset.
module single_port_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [(1<<DEPTH)];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, byte/frame-error pulses.
module uart_rx
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state, counters and output pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: start-bit qualification at half a bit, then full-bit spacing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Program-ROM source: loads an image over UART into word RAM, holds the CPU in
// reset until the image is complete, then serves registered ROM reads.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         WIDTH_D      = 32,
  parameter int         DEPTH        = 8,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               uart_rxd,
  input  logic [DEPTH-1:0]   rom_addr,
  output logic [WIDTH_D-1:0] rom_data,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               frame_error
);

  localparam int NW  = DEPTH + 1;                  // holds 0 .. 1<<DEPTH
  localparam int BPW = WIDTH_D / 8;                // bytes per word
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NW-1:0] FULL_WORDS = NW'(1) << DEPTH;
  localparam logic [IW-1:0] LAST_IDX   = IW'(BPW - 1);

  logic               rx_valid;
  logic [7:0]         rx_byte;
  logic               rx_ferr;

  ld_state_e          state_q, state_d;
  logic [NW-1:0]      n_words_q, n_words_d;
  logic [NW-1:0]      ptr_q, ptr_d;
  logic [NW-1:0]      ptr_inc;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WIDTH_D-1:0] asm_q, asm_d;
  logic [WIDTH_D-1:0] asm_next;
  logic [WIDTH_D+7:0] asm_cat;
  logic               cpu_reset_q, cpu_reset_d;
  logic               load_done_q, load_done_d;
  logic [NW-1:0]      valid_words_q, valid_words_d;
  logic               ferr_q, ferr_d;
  logic               in_range_q, in_range_d;

  logic               ram_we;
  logic [DEPTH-1:0]   ram_addr;
  logic [WIDTH_D-1:0] ram_rdata;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (uart_rxd),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_ferr)
  );

  single_port_ram #(
    .WIDTH(WIDTH_D),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(asm_next),
    .rdata(ram_rdata)
  );

  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign asm_cat  = {rx_byte, asm_q};
  assign asm_next = asm_cat[WIDTH_D+7:8];
  assign ptr_inc  = ptr_q + NW'(1);

  // Loader registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LD_HUNT;
      n_words_q     <= '0;
      ptr_q         <= '0;
      idx_q         <= '0;
      asm_q         <= '0;
      cpu_reset_q   <= 1'b1;
      load_done_q   <= 1'b0;
      valid_words_q <= '0;
      ferr_q        <= 1'b0;
      in_range_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_words_q     <= n_words_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      cpu_reset_q   <= cpu_reset_d;
      load_done_q   <= load_done_d;
      valid_words_q <= valid_words_d;
      ferr_q        <= ferr_d;
      in_range_q    <= in_range_d;
    end
  end

  // Loader next-state, RAM write strobe and CPU handshake outputs.
  always_comb begin
    state_d       = state_q;
    n_words_d     = n_words_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    cpu_reset_d   = cpu_reset_q;
    load_done_d   = load_done_q;
    valid_words_d = valid_words_q;
    ferr_d        = ferr_q | rx_ferr;
    ram_we        = 1'b0;
    unique case (state_q)
      LD_HUNT: begin
        if (rx_valid && rx_byte == HEADER) begin
          state_d       = LD_COUNT;
          cpu_reset_d   = 1'b1;
          load_done_d   = 1'b0;
          valid_words_d = '0;
        end
      end
      LD_COUNT: begin
        if (rx_ferr) begin
          state_d       = LD_HUNT;
          cpu_reset_d   = 1'b1;
          load_done_d   = 1'b0;
          valid_words_d = '0;
          n_words_d     = '0;
        end else if (rx_valid) begin
          n_words_d = (rx_byte == 8'd0) ? FULL_WORDS : NW'(rx_byte);
          ptr_d     = '0;
          idx_d     = '0;
          state_d   = LD_DATA;
        end
      end
      LD_DATA: begin
        if (rx_ferr) begin
          state_d       = LD_HUNT;
          cpu_reset_d   = 1'b1;
          load_done_d   = 1'b0;
          valid_words_d = '0;
          n_words_d     = '0;
        end else if (rx_valid) begin
          asm_d = asm_next;
          if (idx_q == LAST_IDX) begin
            ram_we = 1'b1;
            idx_d  = '0;
            ptr_d  = ptr_inc;
            if (ptr_inc == n_words_q) begin
              state_d       = LD_DONE;
              valid_words_d = n_words_q;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LD_DONE: begin
        // Release lands one cycle after entry; a new header re-asserts reset.
        cpu_reset_d = 1'b0;
        load_done_d = 1'b1;
        if (rx_valid && rx_byte == HEADER) begin
          state_d       = LD_COUNT;
          cpu_reset_d   = 1'b1;
          load_done_d   = 1'b0;
          valid_words_d = '0;
        end
      end
      default: state_d = LD_HUNT;
    endcase
  end

  // RAM address: loader pointer while filling, CPU address otherwise.
  always_comb begin
    ram_addr   = rom_addr;
    in_range_d = 1'b0;
    if (state_q == LD_COUNT || state_q == LD_DATA) begin
      ram_addr = ptr_q[DEPTH-1:0];
    end
    if (state_q == LD_DONE && ({1'b0, rom_addr} < valid_words_q)) begin
      in_range_d = 1'b1;
    end
  end

  assign rom_data    = in_range_q ? ram_rdata : '0;
  assign cpu_reset   = cpu_reset_q;
  assign load_done   = load_done_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed and randomized bench for uart_rom_loader with a word-image model.
module tb_uart_rom_loader;

  localparam int CPB = 8;
  localparam int W   = 32;
  localparam int D   = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          uart_rxd = 1'b1;
  logic [D-1:0]  rom_addr = '0;
  logic [W-1:0]  rom_data;
  logic          cpu_reset;
  logic          load_done;
  logic          frame_error;

  int errors = 0;
  int checks = 0;

  // Reference model: the image the CPU should currently see.
  logic [31:0] model_mem [256];
  int          model_n = 0;

  uart_rom_loader #(
    .CLKS_PER_BIT(CPB),
    .WIDTH_D     (W),
    .DEPTH       (D),
    .HEADER      (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_rxd   (uart_rxd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [31:0] model_word(input int a);
    return (a < model_n) ? model_mem[a] : 32'h0;
  endfunction

  task automatic expect_word(input int a, input string tag);
    @(negedge clk);
    rom_addr = D'(a);
    @(posedge clk);
    #1;
    check(tag, rom_data, model_word(a));
  endtask

  task automatic verify_image(input string tag);
    for (int a = 0; a < model_n + 3 && a < 256; a++) begin
      expect_word(a, tag);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (load_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(load_done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
  endtask

  // Count byte and random words; the model is updated to the new image.
  task automatic send_body(input int n);
    logic [31:0] w;
    logic [31:0] words [$];
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      words.push_back(w);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], 1'b1);
      end
    end
    for (int i = 0; i < n; i++) begin
      model_mem[i] = words[i];
    end
    model_n = n;
  endtask

  task automatic send_image(input int n);
    send_byte(8'hA5, 1'b1);
    model_n = 0;
    send_body(n);
  endtask

  logic [7:0] stream [$];
  logic [7:0] junk;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_rom_data", rom_data, 32'h0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    expect_word(0, "pre_load_read");

    // Directed two-word image.
    stream = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (stream[i]) send_byte(stream[i], 1'b1);
    model_mem[0] = 32'h48000001;
    model_mem[1] = 32'h0;
    model_n = 2;
    wait_done("img1_done");
    expect_word(0, "img1_w0");
    expect_word(1, "img1_w1");
    expect_word(5, "img1_w5");

    // Junk bytes before header are ignored.
    stream = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (stream[i]) send_byte(stream[i], 1'b1);
    model_mem[0] = 32'hDEADBEEF;
    model_n = 1;
    wait_done("img2_done");
    expect_word(0, "img2_w0");
    expect_word(1, "img2_w1");

    // Framing error mid-image aborts the load.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    model_n = 0;
    check("ferr_flag", 32'(frame_error), 32'd1);
    check("ferr_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ferr_load_done", 32'(load_done), 32'd0);
    expect_word(0, "ferr_w0");
    send_image(3);
    wait_done("retry_done");
    verify_image("retry_img");
    check("ferr_sticky", 32'(frame_error), 32'd1);

    // Short glitch on the line must not produce a byte.
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_load_done", 32'(load_done), 32'd1);
    verify_image("glitch_keep");
    send_image(2);
    wait_done("glitch_next_done");
    verify_image("glitch_next_img");

    // Header while holding an image restarts the load.
    send_byte(8'hA5, 1'b1);
    model_n = 0;
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_load_done", 32'(load_done), 32'd0);
    expect_word(0, "restart_w0_hidden");
    send_body(1);
    wait_done("restart_done");
    verify_image("restart_img");

    // Asynchronous reset mid-image; the tail of the stream must not load.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_n = 0;
    check("arst_rom_data", rom_data, 32'h0);
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_load_done", 32'(load_done), 32'd0);
    check("arst_frame_error", 32'(frame_error), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 3; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (30) @(negedge clk);
    check("arst_no_load", 32'(load_done), 32'd0);
    check("arst_hold_cpu", 32'(cpu_reset), 32'd1);
    expect_word(0, "arst_w0");

    // Randomized images preceded by random non-header junk.
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 2; j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, 1'b1);
      end
      send_image(int'($urandom_range(1, 6)));
      wait_done("rand_done");
      verify_image("rand_img");
    end
    check("final_frame_error", 32'(frame_error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
